// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data memory arbiter: FSM states and
// d_size access widths.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIfRd,
    StDRd,
    StDMergeWr,
    StDWr
  } arb_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Byte and half stores need a read-modify-write; 2'b11 behaves as a word.
  function automatic logic is_sub_word(input logic [1:0] size);
    return (size == SIZE_BYTE) || (size == SIZE_HALF);
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational lane formatter: extends load data from the low byte/half and
// merges sub-word store data into the word read from memory.
module mem_lane_fmt
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 32
) (
  input  logic [1:0]           i_size,
  input  logic                 i_unsigned,
  input  logic [DATAWIDTH-1:0] i_rdata,
  input  logic [DATAWIDTH-1:0] i_wdata,
  output logic [DATAWIDTH-1:0] o_load,
  output logic [DATAWIDTH-1:0] o_merge
);

  logic w_sign8;
  logic w_sign16;

  assign w_sign8  = ~i_unsigned & i_rdata[7];
  assign w_sign16 = ~i_unsigned & i_rdata[15];

  always_comb begin
    o_load  = i_rdata;
    o_merge = i_wdata;
    case (i_size)
      SIZE_BYTE: begin
        o_load  = {{(DATAWIDTH-8){w_sign8}}, i_rdata[7:0]};
        o_merge = {i_rdata[DATAWIDTH-1:8], i_wdata[7:0]};
      end
      SIZE_HALF: begin
        o_load  = {{(DATAWIDTH-16){w_sign16}}, i_rdata[15:0]};
        o_merge = {i_rdata[DATAWIDTH-1:16], i_wdata[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one shared single-port memory between an instruction-fetch port
// and a data load/store port, with read-modify-write for sub-word stores.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDRWIDTH = 32,
  parameter int unsigned DATAWIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 if_req,
  input  logic [ADDRWIDTH-1:0] if_addr,
  output logic                 if_ack,
  output logic [DATAWIDTH-1:0] if_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [1:0]           d_size,
  input  logic                 d_unsigned,
  input  logic [ADDRWIDTH-1:0] d_addr,
  input  logic [DATAWIDTH-1:0] d_wdata,
  output logic                 d_ack,
  output logic [DATAWIDTH-1:0] d_rdata,
  output logic [ADDRWIDTH-1:0] mem_address,
  output logic                 mem_read_write,
  output logic [DATAWIDTH-1:0] mem_wdata,
  input  logic [DATAWIDTH-1:0] mem_rdata
);

  arb_state_e           r_state;
  logic                 r_if_ack;
  logic                 r_d_ack;
  logic [DATAWIDTH-1:0] r_if_rdata;
  logic [DATAWIDTH-1:0] r_d_rdata;
  logic [ADDRWIDTH-1:0] r_mem_address;
  logic                 r_mem_rw;
  logic [DATAWIDTH-1:0] r_mem_wdata;
  // Winner of the most recent contended IDLE cycle (1 = data); the other side
  // takes the next tie. Reset to fetch so data wins the first tie.
  logic                 r_tie_d;

  logic                 w_if_elig;
  logic                 w_d_elig;
  logic                 w_grant_d;
  logic                 w_d_sub;
  logic [DATAWIDTH-1:0] w_load;
  logic [DATAWIDTH-1:0] w_merge;

  // A port whose ack is showing still has req high; it must not be re-served.
  assign w_if_elig = if_req & ~r_if_ack;
  assign w_d_elig  = d_req & ~r_d_ack;
  assign w_grant_d = w_d_elig & (~w_if_elig | ~r_tie_d);
  assign w_d_sub   = is_sub_word(d_size);

  mem_lane_fmt #(
    .DATAWIDTH(DATAWIDTH)
  ) u_lane_fmt (
    .i_size    (d_size),
    .i_unsigned(d_unsigned),
    .i_rdata   (mem_rdata),
    .i_wdata   (d_wdata),
    .o_load    (w_load),
    .o_merge   (w_merge)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= StIdle;
      r_if_ack      <= 1'b0;
      r_d_ack       <= 1'b0;
      r_if_rdata    <= '0;
      r_d_rdata     <= '0;
      r_mem_address <= '0;
      r_mem_rw      <= 1'b0;
      r_mem_wdata   <= '0;
      r_tie_d       <= 1'b0;
    end else begin
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_if_elig && w_d_elig) r_tie_d <= w_grant_d;
          if (w_grant_d) begin
            r_mem_address <= d_addr;
            if (d_we && !w_d_sub) begin
              r_state     <= StDWr;
              r_mem_rw    <= 1'b1;
              r_mem_wdata <= d_wdata;
            end else begin
              r_state <= StDRd;
            end
          end else if (w_if_elig) begin
            r_mem_address <= if_addr;
            r_state       <= StIfRd;
          end
        end
        StIfRd: begin
          r_if_rdata    <= mem_rdata;
          r_if_ack      <= 1'b1;
          r_mem_address <= '0;
          r_state       <= StIdle;
        end
        StDRd: begin
          if (d_we) begin
            r_mem_wdata <= w_merge;
            r_mem_rw    <= 1'b1;
            r_state     <= StDMergeWr;
          end else begin
            r_d_rdata     <= w_load;
            r_d_ack       <= 1'b1;
            r_mem_address <= '0;
            r_state       <= StIdle;
          end
        end
        StDMergeWr, StDWr: begin
          r_mem_rw      <= 1'b0;
          r_d_ack       <= 1'b1;
          r_mem_address <= '0;
          r_state       <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign if_ack         = r_if_ack;
  assign if_rdata       = r_if_rdata;
  assign d_ack          = r_d_ack;
  assign d_rdata        = r_d_rdata;
  assign mem_address    = r_mem_address;
  assign mem_read_write = r_mem_rw;
  assign mem_wdata      = r_mem_wdata;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDRWIDTH, default 32, address width; DATAWIDTH, default 32, data width.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 if_req  input  1  instruction-fetch read request, held high until if_ack.
REQ-005 if_addr  input  ADDRWIDTH  fetch byte address, stable while if_req high.
REQ-006 if_ack  output  1  one-cycle pulse: fetch done, if_rdata valid.
REQ-007 if_rdata  output  DATAWIDTH  registered fetch word.
REQ-008 d_req  input  1  data request, held high until d_ack.
REQ-009 d_we  input  1  1 = store, 0 = load.
REQ-010 d_size  input  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-011 d_unsigned  input  1  load zero-extend when 1, sign-extend when 0.
REQ-012 d_addr  input  ADDRWIDTH  data byte address; any alignment legal.
REQ-013 d_wdata  input  DATAWIDTH  store data, right-aligned.
REQ-014 d_ack  output  1  one-cycle pulse: data access done, d_rdata valid for loads.
REQ-015 d_rdata  output  DATAWIDTH  registered, extended load result.
REQ-016 mem_address  output  ADDRWIDTH  shared memory byte address.
REQ-017 mem_read_write  output  1  1 = write on next clock edge, 0 = combinational read.
REQ-018 mem_wdata  output  DATAWIDTH  write word to memory.
REQ-019 mem_rdata  input  DATAWIDTH  combinational little-endian word {addr+3..addr} from memory.

Function
REQ-020 FSM states SHALL be IDLE, IF_RD, D_RD, D_MERGE_WR, D_WR.
REQ-021 IDLE: if only one requester is eligible, that requester SHALL be served; if both, the one not served last SHALL win.
REQ-022 A requester SHALL be ineligible in the cycle its ack is high.
REQ-023 Transitions from IDLE: fetch -> IF_RD; load -> D_RD; word store -> D_WR; byte/half store -> D_RD.
REQ-024 IF_RD SHALL drive if_addr with read_write 0, capture mem_rdata into if_rdata, pulse if_ack in the following cycle, and return to IDLE.
REQ-025 D_RD for a load SHALL drive d_addr, capture the extended low byte, half or word into d_rdata, pulse d_ack in the following cycle, and return to IDLE.
REQ-026 D_RD for a sub-word store SHALL capture mem_rdata into a merge register and go to D_MERGE_WR.
REQ-027 D_MERGE_WR SHALL drive mem_read_write 1 with the merged word: d_wdata[7:0] or [15:0] replacing the low byte or half, upper bytes unchanged. It SHALL then pulse d_ack and go to IDLE.
REQ-028 D_WR SHALL drive mem_read_write 1 with d_wdata, then pulse d_ack and go to IDLE.
REQ-029 Latency from req sampled in IDLE to ack SHALL be: 2 cycles for fetch, load and word store; 3 cycles for byte/half store.
REQ-030 mem_read_write SHALL be 0 in every state other than D_MERGE_WR and D_WR.
REQ-031 In IDLE, mem_address SHALL be 0.
REQ-032 Load extension SHALL use bit 7 (byte) or bit 15 (half) when d_unsigned is 0.
REQ-033 Acks SHALL never be high for both ports in one cycle.
REQ-034 No request SHALL wait more than one competing access (fairness).
REQ-035 Inputs changing while the associated request is pending SHALL be a protocol violation with undefined result.

Reset
REQ-036 Reset SHALL force: state IDLE; if_ack, d_ack, mem_read_write and mem_address 0; if_rdata and d_rdata 0; last-served flag = fetch, so data wins the first tie.
REQ-037 Reset asserted mid-access SHALL abort the access without a memory write and without an ack; requesters re-issue after reset.

Structure
REQ-038 A shared package mem_arb_pkg SHALL hold the FSM state encoding and the d_size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD).
REQ-039 Store merge and load extension SHALL be one combinational sub-module, mem_lane_fmt.

Verification
REQ-040 Test 1: fetch only, if_addr=0x01000000, memory holds 0x00500093 -> if_ack 2 cycles later, if_rdata=0x00500093, mem_read_write never 1.
REQ-041 Test 2: if_req and d_req load rise in the same cycle after reset -> d_ack first (cycle 2), if_ack cycle 4; repeat the pair -> fetch served first.
REQ-042 Test 3: byte store d_wdata=0x000000AB to a word holding 0x11223344 -> D_RD, D_MERGE_WR, d_ack at cycle 3; memory holds 0x112233AB.
REQ-043 Test 4: signed half load of 0x0000F00D -> d_rdata=0xFFFFF00D; unsigned -> 0x0000F00D.
REQ-044 Test 5: reset asserted during D_MERGE_WR -> no memory change, no d_ack, state IDLE immediately.
REQ-045 Test 6: misaligned word store at 0x01000002 with 0xDEADBEEF -> bytes 0x2..0x5 = EF BE AD DE, ack at 2 cycles.
